// File: rtl/cla_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial CLA adder/subtractor.
package cla_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/CLA4Bit.sv
// 4-bit carry-lookahead adder slice with group propagate/generate outputs.
module CLA4Bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       carryIn,
    output logic [3:0] Sum,
    output logic       carryOut,
    output logic       PG,
    output logic       GG
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = A & B;
    assign p_s = A ^ B;

    // Every carry is flattened to two logic levels from the slice inputs.
    assign c_s[0] = carryIn;
    assign c_s[1] = g_s[0] | (p_s[0] & carryIn);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & carryIn);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & carryIn);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & carryIn);

    assign Sum      = p_s ^ c_s[3:0];
    assign carryOut = c_s[4];
    assign PG       = &p_s;
    assign GG       = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                    | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);

endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// Wide add/subtract built by time-sharing one CLA4Bit slice, LSB nibble first,
// with a registered carry between passes and valid/ready handshakes on both sides.
module cla_serial_adder_ctrl
    import cla_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
            $error("cla_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t               state_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic                 carry_r;
    logic [IDX_W-1:0]     idx_r;
    logic [WIDTH-1:0]     sum_r;
    logic                 cout_r;
    logic                 ovf_r;

    logic [NIBBLE_W-1:0]  slice_a_s;
    logic [NIBBLE_W-1:0]  slice_b_s;
    logic [NIBBLE_W-1:0]  slice_sum_s;
    logic                 slice_cout_s;
    logic                 slice_pg_s;
    logic                 slice_gg_s;
    logic                 slice_unused_s;

    // Select the operand nibbles for the current pass.
    always_comb begin
        slice_a_s = a_r[idx_r*NIBBLE_W +: NIBBLE_W];
        slice_b_s = b_r[idx_r*NIBBLE_W +: NIBBLE_W];
    end

    CLA4Bit u_cla4 (
        .A        (slice_a_s),
        .B        (slice_b_s),
        .carryIn  (carry_r),
        .Sum      (slice_sum_s),
        .carryOut (slice_cout_s),
        .PG       (slice_pg_s),
        .GG       (slice_gg_s)
    );

    // Group propagate/generate are not needed for a single ripple of passes.
    assign slice_unused_s = slice_pg_s ^ slice_gg_s;

    // Sequencer: capture operands, run NIB passes, hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        // Subtraction is A + ~B + 1, so the +1 rides in on the carry.
                        b_r     <= b ^ {WIDTH{sub}};
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= '0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[idx_r*NIBBLE_W +: NIBBLE_W] <= slice_sum_s;
                    carry_r <= slice_cout_s;
                    if (idx_r == LAST_IDX) begin
                        cout_r  <= slice_cout_s;
                        ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                   (slice_sum_s[NIBBLE_W-1] != a_r[WIDTH-1]);
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Randomized self-checking bench for cla_serial_adder_ctrl against an arithmetic model.
module tb_cla_serial_adder_ctrl;

    localparam int W = 16;
    localparam int EXP_LAT = W / 4 + 1;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_vec;
    int n_err;

    cla_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                  input logic tsub, input logic tcin,
                                  output logic [W-1:0] s, output logic c, output logic o);
        int unsigned full;
        int sa;
        int sb;
        int sr;
        logic [W-1:0] nb;
        sa = int'($signed(ta));
        sb = int'($signed(tb_));
        nb = ~tb_;
        if (tsub) begin
            full = int'(ta) + int'(nb) + 1;
            sr   = sa - sb;
        end else begin
            full = int'(ta) + int'(tb_) + int'(tcin);
            sr   = sa + sb + int'(tcin);
        end
        s = full[W-1:0];
        c = full[W];
        o = (sr > 32767) || (sr < -32768);
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tsub, input logic tcin, input int hold);
        logic [W-1:0] es;
        logic ec;
        logic eo;
        int lat;
        int w;
        model(ta, tb_, tsub, tcin, es, ec, eo);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        a = ta; b = tb_; sub = tsub; cin = tcin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(EXP_LAT));
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        check("ovf", 32'(ovf), 32'(eo));
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            @(posedge clk);
            #1;
            check("stall_sum", 32'(sum), 32'(es));
            check("stall_flags", {30'd0, cout, ovf}, {30'd0, ec, eo});
            check("stall_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("after_handshake_valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
        check("idle_sum_held", 32'(sum), 32'(es));
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_flags", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 3);

        // Async reset in the middle of a pass sequence, carry register loaded with 1.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_reset_valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
        check("midrun_reset_sum", 32'(sum), 32'd0);
        check("midrun_reset_flags", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
